// File: rtl/cnt60_bcd.sv
// Two-digit BCD modulo-60 counter with synchronous range-checked preset and a
// cascadable combinational terminal count. Define CNT60_DOWN_EN to add the UP port and down counting.
module cnt60_bcd (
  input  logic       Clk,
  input  logic       MR,
  input  logic       EN,
  input  logic       LD,
  input  logic [2:0] D_TENS,
  input  logic [3:0] D_ONES,
`ifdef CNT60_DOWN_EN
  input  logic       UP,
`endif
  output logic [2:0] Q_TENS,
  output logic [3:0] Q_ONES,
  output logic       TC,
  output logic       ERR
);

  logic [2:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       err_q, err_d;
  logic       preset_ok;
  logic       at_max;
  logic       count_up;

  assign preset_ok = (D_TENS <= 3'd5) && (D_ONES <= 4'd9);
  assign at_max    = (tens_q == 3'd5) && (ones_q == 4'd9);

`ifdef CNT60_DOWN_EN
  logic at_min;
  assign at_min   = (tens_q == 3'd0) && (ones_q == 4'd0);
  assign count_up = UP;
`else
  assign count_up = 1'b1;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    tens_d = tens_q;
    ones_d = ones_q;
    err_d  = err_q;
    if (LD) begin
      if (preset_ok) begin
        tens_d = D_TENS;
        ones_d = D_ONES;
      end else begin
        err_d = 1'b1;
      end
    end else if (EN) begin
      if (count_up) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = (tens_q == 3'd5) ? 3'd0 : tens_q + 3'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
`ifdef CNT60_DOWN_EN
      else begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = (tens_q == 3'd0) ? 3'd5 : tens_q - 3'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
`endif
    end
  end

  // NOTE: state uses non-blocking assignments and clears asynchronously on MR low.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      tens_q <= 3'd0;
      ones_q <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      err_q  <= err_d;
    end
  end

  // MR gating keeps TC low during reset even when the down decode (00) would match.
`ifdef CNT60_DOWN_EN
  assign TC = MR & EN & ~LD & (count_up ? at_max : at_min);
`else
  assign TC = MR & EN & ~LD & at_max;
`endif

  assign Q_TENS = tens_q;
  assign Q_ONES = ones_q;
  assign ERR    = err_q;

endmodule

// File: doc/cnt60_bcd.md
# cnt60_bcd

Two-digit BCD modulo-60 counter sitting directly downstream of the mod-12 counter stage. It takes that stage's terminal-count pulse as its count enable, so that one count-60 step occurs per full mod-12 cycle. It exposes a cascadable terminal count of its own, so further stages can chain off it. The block also provides synchronous preset with range checking, for time-of-day style settings.

## Interface
- No parameters.
- Clk  input  1  rising-edge clock, shared with the upstream mod-12 counter.
- MR  input  1  master reset, asynchronous, active-low.
- EN  input  1  count enable; driven by upstream TC; one step per Clk edge while high.
- LD  input  1  synchronous load strobe.
- D_TENS  input  3  preset tens digit; legal 0–5.
- D_ONES  input  4  preset ones digit; legal 0–9.
- UP  input  1  count direction, 1 = up; present only with CNT60_DOWN_EN.
- Q_TENS  output  3  tens digit, registered.
- Q_ONES  output  4  ones digit, registered.
- TC  output  1  terminal count, combinational (see Operation).
- ERR  output  1  sticky illegal-preset flag, registered.

## Operation
- Reset, with MR low: Q_TENS=0, Q_ONES=0, ERR=0, TC=0. All registers clear immediately, independent of Clk.
- Priority per Clk edge: LD > EN > hold.
- LD=1 with a legal preset (D_TENS≤5 and D_ONES≤9):
  - Q_TENS:Q_ONES ← D_TENS:D_ONES.
  - EN is ignored that cycle.
  - ERR is unchanged.
- LD=1 with an illegal preset:
  - Q_TENS and Q_ONES hold their previous values.
  - ERR ← 1.
  - ERR stays at 1 until MR goes low; nothing else clears it.
- LD=0, EN=1, counting up (ones digit):
  - Q_ONES increments.
  - At Q_ONES=9 the next value is 0 and the tens digit advances.
- LD=0, EN=1, counting up (tens digit):
  - Q_TENS increments on a ones rollover.
  - At 5:9 the next value is 0:0 (wrap-around).
- LD=0, EN=0: hold.
- TC = EN & ~LD & (Q == 5:9) when counting up.
- TC is never asserted while MR is low.
- Q_TENS:Q_ONES never leaves the legal range 00–59 by construction.

## Timing
- Q_TENS, Q_ONES and ERR change only on the Clk rising edge, or asynchronously on MR falling.
- Count latency is 1 cycle: EN high at edge N gives the new value visible after edge N.
- Load latency is 1 cycle, the same as count latency.
- TC is combinational from EN, LD and the current state.
- TC is high for exactly one cycle per wrap when EN is a one-cycle pulse. Downstream stages sample it on the same Clk edge.
- EN is expected to be synchronous to Clk, being the upstream registered-state TC. No internal synchronizer.
- MR release: the first count can occur on the first Clk edge after MR goes high.
- MR asserted mid-count or mid-load aborts the operation; outputs read 00 with ERR=0.

## Configuration
- Macro CNT60_DOWN_EN.
- Defined:
  - The UP port exists.
  - With UP=0 and EN=1, the counter decrements: ones 0→9 with a tens borrow, and 0:0 → 5:9.
  - When counting down, TC = EN & ~LD & (Q == 0:0).
  - Counting up is unchanged.
- Undefined:
  - The UP port is absent.
  - The counter is up-only, and TC decodes 5:9 only.
- Reset, load and ERR behaviour are identical in both builds.

## Test plan
- Reset then enable: MR=0 for 10 ns, then 1; EN held high for 60 cycles.
  - Q steps 00, 01 … 59, 00.
  - TC is high only in the cycle where Q=59.
- Upstream pairing: EN driven by a one-cycle pulse every 12 cycles, 20 ns clock.
  - After 12×60 cycles Q=00.
  - TC has pulsed once.
- Legal load: LD=1 with D=4:7 and EN=1 simultaneously.
  - Q=47 next cycle with no increment; ERR=0.
- Illegal load: Q=23, then LD with D=6:0, then LD with D=2:A.
  - Q stays 23; ERR=1 and stays 1.
  - Next MR pulse: Q=00 and ERR=0.
- Asynchronous reset mid-run: Q=38 with EN high; MR pulled low between clock edges.
  - Q=00 and TC=0 before the next edge.
- With CNT60_DOWN_EN, UP=0, EN=1 from Q=01.
  - Sequence 00, 59, 58.
  - TC is high only in the cycle where Q=00.
